// File: rtl/pic_register_file_pkg.sv
// Shared constants, command layout and GPR index mapping for the PIC file-register stage.
package pic_register_file_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;
  localparam logic [4:0] ADDR_PORTA  = 5'h05;
  localparam logic [4:0] ADDR_PORTB  = 5'h06;
  localparam logic [4:0] ADDR_PORTC  = 5'h07;
  localparam logic [4:0] ADDR_SHARED = 5'h08;
  localparam logic [4:0] ADDR_BANKED = 5'h10;

  localparam logic [7:0] STATUS_RST = 8'h18;
  localparam logic [7:0] PORT_RST   = 8'hFF;

  localparam int STATUS_C  = 0;
  localparam int STATUS_DC = 1;
  localparam int STATUS_Z  = 2;
  localparam int STATUS_PD = 3;
  localparam int STATUS_TO = 4;
  localparam int STATUS_PA = 5;

  // TO/PD are hardware-owned; the flag and page fields are software-writable.
  localparam logic [7:0] STATUS_HW_MASK = 8'h18;
  localparam logic [7:0] STATUS_LO_MASK = 8'h07;

  localparam int CMD_STATUS = 0;
  localparam int CMD_GPR    = 1;
  localparam int CMD_FSR    = 2;

  // Member order matches bit order of the 3-bit command word ([2] first).
  typedef struct packed {
    logic latch_addr;
    logic write_gpr;
    logic write_status;
  } write_cmd_t;

  // Shared 0x08-0x0F map to 0..7; banked 0x10-0x1F map to 8 + bank*16 + offset.
  function automatic logic [6:0] gpr_index(input logic [4:0] addr, input logic [1:0] bank);
    if (addr[4]) begin
      return 7'd8 + {1'b0, bank, addr[3:0]};
    end
    return {4'b0000, addr[2:0]};
  endfunction

endpackage

// File: rtl/pic_register_file_gpr.sv
// GPR RAM: shared plus banked registers, one synchronous write port and a combinational read port.
module pic_gpr_bank
  import pic_register_file_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [4:0]            addr,
  input  logic [1:0]            bank,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 8 + 16 * NUM_BANKS;
  localparam int IW    = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [1:0]            bank_eff;
  logic [6:0]            idx;

  // Bank bits above the implemented bank count are ignored.
  assign bank_eff  = bank & 2'(NUM_BANKS - 1);
  assign idx       = gpr_index(addr, bank_eff);
  assign read_data = mem[idx[IW-1:0]];

  always_ff @(posedge clk) begin
    if (write_en && addr >= ADDR_SHARED) begin
      mem[idx[IW-1:0]] <= write_data;
    end
  end

endmodule

// File: rtl/pic_register_file.sv
// File-register stage: special registers, address latch, read mux and banked GPR RAM.
module pic_register_file
  import pic_register_file_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            writeCommand,
  input  logic [4:0]            fileAddrIn,
  input  logic [DATA_WIDTH-1:0] gprWriteDataIn,
  input  logic [DATA_WIDTH-1:0] statusWriteData,
  input  logic                  tmr0IncIn,
  input  logic [DATA_WIDTH-1:0] pcLowIn,
  output logic [DATA_WIDTH-1:0] gprReadDataOut,
  output logic [DATA_WIDTH-1:0] gprStatusOut,
  output logic [DATA_WIDTH-1:0] fsrOut,
  output logic                  pclWriteEnOut,
  output logic [DATA_WIDTH-1:0] pclWriteDataOut,
  output logic [DATA_WIDTH-1:0] portAOut,
  output logic [DATA_WIDTH-1:0] portBOut,
  output logic [DATA_WIDTH-1:0] portCOut
);

  write_cmd_t            cmd;
  logic [4:0]            addr_q;
  logic [4:0]            eff_addr;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] fsr_q, fsr_read;
  logic [DATA_WIDTH-1:0] tmr0_q;
  logic [DATA_WIDTH-1:0] port_a_q, port_b_q, port_c_q;
  logic                  pcl_we_q;
  logic [DATA_WIDTH-1:0] pcl_data_q;
  logic [DATA_WIDTH-1:0] ram_read;
  logic                  gpr_we;
  logic                  hit_tmr0, hit_pcl, hit_status, hit_fsr;
  logic                  hit_port_a, hit_port_b, hit_port_c;

  assign cmd = writeCommand;

  // INDF substitutes FSR[4:0]; an effective address of 0 means INDF pointing at itself.
  assign eff_addr = (addr_q == ADDR_INDF) ? fsr_q[4:0] : addr_q;

  assign gpr_we     = cmd.write_gpr && (eff_addr != ADDR_INDF);
  assign hit_tmr0   = gpr_we && (eff_addr == ADDR_TMR0);
  assign hit_pcl    = gpr_we && (eff_addr == ADDR_PCL);
  assign hit_status = gpr_we && (eff_addr == ADDR_STATUS);
  assign hit_fsr    = gpr_we && (eff_addr == ADDR_FSR);
  assign hit_port_a = gpr_we && (eff_addr == ADDR_PORTA);
  assign hit_port_b = gpr_we && (eff_addr == ADDR_PORTB);
  assign hit_port_c = gpr_we && (eff_addr == ADDR_PORTC);

  pic_gpr_bank #(
    .NUM_BANKS  (NUM_BANKS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gpr_bank (
    .clk        (clk),
    .write_en   (gpr_we && rst_n),
    .addr       (eff_addr),
    .bank       (fsr_q[6:5]),
    .write_data (gprWriteDataIn),
    .read_data  (ram_read)
  );

  // A same-cycle flag update overrides the low bits of a GPR write to STATUS.
  always_comb begin
    status_d = status_q;
    if (hit_status) begin
      status_d = (status_q & STATUS_HW_MASK) | (gprWriteDataIn & ~STATUS_HW_MASK);
    end
    if (cmd.write_status) begin
      if (hit_status) begin
        status_d = (status_d & ~STATUS_LO_MASK) | (statusWriteData & STATUS_LO_MASK);
      end else begin
        status_d = (status_q & STATUS_HW_MASK) | (statusWriteData & ~STATUS_HW_MASK);
      end
    end
  end

  always_comb begin
    fsr_read = fsr_q;
    if (NUM_BANKS < 4) fsr_read[6] = 1'b1;
    if (NUM_BANKS < 2) fsr_read[5] = 1'b1;
  end

  always_comb begin
    gprReadDataOut = ram_read;
    case (eff_addr)
      ADDR_INDF:   gprReadDataOut = '0;
      ADDR_TMR0:   gprReadDataOut = tmr0_q;
      ADDR_PCL:    gprReadDataOut = pcLowIn;
      ADDR_STATUS: gprReadDataOut = status_q;
      ADDR_FSR:    gprReadDataOut = fsr_read;
      ADDR_PORTA:  gprReadDataOut = port_a_q;
      ADDR_PORTB:  gprReadDataOut = port_b_q;
      ADDR_PORTC:  gprReadDataOut = port_c_q;
      default:     gprReadDataOut = ram_read;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      status_q   <= STATUS_RST;
      fsr_q      <= '0;
      tmr0_q     <= '0;
      port_a_q   <= PORT_RST;
      port_b_q   <= PORT_RST;
      port_c_q   <= PORT_RST;
      pcl_we_q   <= 1'b0;
      pcl_data_q <= '0;
    end else begin
      if (cmd.latch_addr) addr_q <= fileAddrIn;
      status_q <= status_d;
      if (hit_fsr)    fsr_q    <= gprWriteDataIn;
      if (hit_port_a) port_a_q <= gprWriteDataIn;
      if (hit_port_b) port_b_q <= gprWriteDataIn;
      if (hit_port_c) port_c_q <= gprWriteDataIn;
      // Software write to TMR0 takes priority over the prescaler tick.
      if (hit_tmr0) begin
        tmr0_q <= gprWriteDataIn;
      end else if (tmr0IncIn) begin
        tmr0_q <= tmr0_q + 1'b1;
      end
      pcl_we_q <= hit_pcl;
      if (hit_pcl) pcl_data_q <= gprWriteDataIn;
    end
  end

  assign gprStatusOut    = status_q;
  assign fsrOut          = fsr_q;
  assign pclWriteEnOut   = pcl_we_q;
  assign pclWriteDataOut = pcl_data_q;
  assign portAOut        = port_a_q;
  assign portBOut        = port_b_q;
  assign portCOut        = port_c_q;

endmodule
